// File: rtl/i2c_bus_conditioner_pkg.sv
// Purpose: shared constants, bus-state encoding and width helpers for the i2c bus conditioner.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   I2C_SYNC_STAGES    default synchroniser depth per line
//   I2C_FILTER_LEN     default glitch-filter length in clk cycles
//   I2C_TIMEOUT_CYCLES default SCL-low timeout, used only when I2C_BUS_TIMEOUT_EN is defined
//   bus_state_t        idle/busy encoding of the bus-occupancy FSM
package i2c_pkg;

    localparam int I2C_SYNC_STAGES    = 2;
    localparam int I2C_FILTER_LEN     = 3;
    localparam int I2C_TIMEOUT_CYCLES = 50000;

    typedef enum logic {
        BUS_IDLE = 1'b0,
        BUS_BUSY = 1'b1
    } bus_state_t;

    // Filter counter only has to reach FILTER_LEN-1; keep at least one bit
    // so that FILTER_LEN == 1 still yields a legal vector.
    function automatic int filt_cnt_width(input int filter_len);
        return (filter_len > 1) ? $clog2(filter_len) : 1;
    endfunction

    // Timeout counter must be able to hold TIMEOUT_CYCLES itself, because
    // it parks on that value until SCL goes high again.
    function automatic int tmo_cnt_width(input int timeout_cycles);
        return $clog2(timeout_cycles + 1);
    endfunction

endpackage

// File: rtl/i2c_bus_conditioner_if.sv
// Purpose: bundles the raw pad inputs and the conditioned outputs of the i2c bus conditioner.
// Latency: n/a (wiring only).
// Backpressure: none; every signal is a level or a single-cycle strobe.
//
// Signals:
//   scl_i, sda_i          raw asynchronous pad levels
//   scl_f, sda_f          filtered levels
//   scl_rise, scl_fall    one-cycle strobes on filtered SCL edges
//   start_det, stop_det   one-cycle strobes on START / STOP
//   bus_busy              high between START and STOP
//   timeout               one-cycle strobe on SCL-low timeout (0 when the feature is absent)
// Modports: master = pad/consumer side, slave = the conditioner itself.
interface i2c_bus_conditioner_if;

    logic scl_i;
    logic sda_i;
    logic scl_f;
    logic sda_f;
    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;
    logic bus_busy;
    logic timeout;

    modport master (
        output scl_i,
        output sda_i,
        input  scl_f,
        input  sda_f,
        input  scl_rise,
        input  scl_fall,
        input  start_det,
        input  stop_det,
        input  bus_busy,
        input  timeout
    );

    modport slave (
        input  scl_i,
        input  sda_i,
        output scl_f,
        output sda_f,
        output scl_rise,
        output scl_fall,
        output start_det,
        output stop_det,
        output bus_busy,
        output timeout
    );

endinterface

// File: rtl/i2c_line_filter.sv
// Purpose: synchroniser chain plus glitch filter for one open-drain i2c line.
// Latency: a stable pin change reaches line_f exactly SYNC_STAGES+FILTER_LEN cycles later.
// Backpressure: none; samples the pin every clk.
//
// Ports:
//   clk, reset  clock and synchronous active-high reset (line resets to 1 = idle)
//   line_i      raw asynchronous pad level
//   line_f      filtered level
//   flip        combinational: line_f takes the opposite value at the next clk edge
module i2c_line_filter
    import i2c_pkg::*;
#(
    parameter int SYNC_STAGES = I2C_SYNC_STAGES,
    parameter int FILTER_LEN  = I2C_FILTER_LEN
) (
    input  logic clk,
    input  logic reset,
    input  logic line_i,
    output logic line_f,
    output logic flip
);

    localparam int CNT_W = filt_cnt_width(FILTER_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic                   line_q;
    logic                   line_d;

    // Bit 0 takes the pad, the top bit is the metastability-settled sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], line_i};
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];

    // The counter measures how long synced has disagreed with the output.
    // Any agreement restarts it, so a run shorter than FILTER_LEN samples
    // is discarded entirely.
    always_comb begin
        cnt_d  = cnt_q;
        line_d = line_q;
        flip   = 1'b0;
        if (synced == line_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            flip   = 1'b1;
            line_d = synced;
            cnt_d  = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            line_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            line_q <= line_d;
        end
    end

    assign line_f = line_q;

endmodule

// File: rtl/i2c_bus_conditioner.sv
// Purpose: i2c pad front end: clean SCL/SDA, SCL edge strobes, START/STOP strobes, bus-busy, optional SCL-low timeout.
// Latency: pins to scl_f/sda_f SYNC_STAGES+FILTER_LEN cycles; strobes coincide with the filtered change; bus_busy one cycle later.
// Backpressure: none; outputs are levels and single-cycle strobes that the consumer must sample every cycle.
//
// Ports:
//   clk    system clock
//   reset  synchronous, active-high; returns the block to an idle bus with no strobes
//   bus    i2c_bus_conditioner_if.slave (scl_i/sda_i in; filtered levels, strobes, bus_busy, timeout out)
// Optional feature: define I2C_BUS_TIMEOUT_EN to build the SCL-low timeout counter;
// without it timeout is tied 0 and bus_busy follows START/STOP/reset only.
module i2c_bus_conditioner
    import i2c_pkg::*;
#(
    parameter int SYNC_STAGES    = I2C_SYNC_STAGES,
    parameter int FILTER_LEN     = I2C_FILTER_LEN,
    parameter int TIMEOUT_CYCLES = I2C_TIMEOUT_CYCLES
) (
    input  logic                  clk,
    input  logic                  reset,
    i2c_bus_conditioner_if.slave  bus
);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("i2c_bus_conditioner: SYNC_STAGES must be at least 2");
    end
    if (FILTER_LEN < 1) begin : g_bad_filt
        $error("i2c_bus_conditioner: FILTER_LEN must be at least 1");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_tmo
        $error("i2c_bus_conditioner: TIMEOUT_CYCLES must be at least 1");
    end

    logic scl_lvl;
    logic sda_lvl;
    logic scl_flip;
    logic sda_flip;

    logic scl_rise_q;
    logic scl_fall_q;
    logic start_q;
    logic stop_q;
    logic tmo_q;

    bus_state_t state_q;
    bus_state_t state_d;

    i2c_line_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_scl_filter (
        .clk    (clk),
        .reset  (reset),
        .line_i (bus.scl_i),
        .line_f (scl_lvl),
        .flip   (scl_flip)
    );

    i2c_line_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_sda_filter (
        .clk    (clk),
        .reset  (reset),
        .line_i (bus.sda_i),
        .line_f (sda_lvl),
        .flip   (sda_flip)
    );

    // Strobes are registered from the filters' flip indication, so they are
    // high in exactly the cycle the filtered level first shows its new value.
    // START/STOP need SCL high both before and after the SDA change: scl_lvl
    // covers "before", !scl_flip guarantees "after". A simultaneous SCL/SDA
    // change therefore produces SCL edge strobes only.
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_rise_q <= 1'b0;
            scl_fall_q <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
        end else begin
            scl_rise_q <= scl_flip & ~scl_lvl;
            scl_fall_q <= scl_flip &  scl_lvl;
            start_q    <= sda_flip &  sda_lvl & scl_lvl & ~scl_flip;
            stop_q     <= sda_flip & ~sda_lvl & scl_lvl & ~scl_flip;
        end
    end

`ifdef I2C_BUS_TIMEOUT_EN
    localparam int TMO_W = tmo_cnt_width(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_cnt_q;

    // Counts busy cycles with SCL low. Once it reaches TIMEOUT_CYCLES it
    // parks there (even though the bus drops to idle) so the strobe cannot
    // re-fire; only a filtered SCL high re-arms it.
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt_q <= '0;
            tmo_q     <= 1'b0;
        end else begin
            tmo_q <= 1'b0;
            if (scl_lvl) begin
                tmo_cnt_q <= '0;
            end else if (tmo_cnt_q == TMO_MAX) begin
                tmo_cnt_q <= tmo_cnt_q;
            end else if (state_q != BUS_BUSY) begin
                tmo_cnt_q <= '0;
            end else begin
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
                if (tmo_cnt_q == TMO_LAST) begin
                    tmo_q <= 1'b1;
                end
            end
        end
    end
`else
    assign tmo_q = 1'b0;
`endif

    // Bus occupancy. A repeated START while busy keeps BUSY; a STOP while
    // idle keeps IDLE. Both transitions land the cycle after the strobe.
    always_comb begin
        state_d = state_q;
        case (state_q)
            BUS_IDLE: begin
                if (start_q) begin
                    state_d = BUS_BUSY;
                end
            end
            BUS_BUSY: begin
                if (stop_q || tmo_q) begin
                    state_d = BUS_IDLE;
                end
            end
            default: state_d = BUS_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= BUS_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign bus.scl_f     = scl_lvl;
    assign bus.sda_f     = sda_lvl;
    assign bus.scl_rise  = scl_rise_q;
    assign bus.scl_fall  = scl_fall_q;
    assign bus.start_det = start_q;
    assign bus.stop_det  = stop_q;
    assign bus.bus_busy  = (state_q == BUS_BUSY);
    assign bus.timeout   = tmo_q;

endmodule
